// File: rtl/poolb_row_pair_feeder.sv
// poolb_row_pair_feeder
// Upstream feeder for the 3-lane 2x2 pooling datapath. The conv output
// arrives in raster order, one pixel per lane per valid cycle. Each even
// row is stored in a per-lane line buffer. While the following odd row
// streams in, the block emits vertically aligned row pairs
// (A = even-row pixel, B = odd-row pixel) one cycle after each odd-row
// pixel. It also reports plane and layer completion.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous reset, active low
//   start                one-cycle pulse, begins a layer (IFM_DEPTH/3 planes)
//   in_valid             data_in_unit1..3 carry a valid pixel
//   data_in_unit1..3     per-lane conv pixels
//   fifo_enable          A/B outputs carry a new row pair
//   pool_enable          the current pair closes a 2x2 window (odd column)
//   data_out_A_unit1..3  even-row pixel at the current column
//   data_out_B_unit1..3  odd-row pixel at the current column
//   plane_done           pulse one cycle after the last pair of a plane
//   layer_done           pulse one cycle after the last pair of the layer
//   busy                 high from the cycle after start until layer_done
module poolb_row_pair_feeder #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 10,
  parameter int IFM_DEPTH   = 30,
  parameter int KERNAL_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in_unit1,
  input  logic [DATA_WIDTH-1:0] data_in_unit2,
  input  logic [DATA_WIDTH-1:0] data_in_unit3,
  output logic                  fifo_enable,
  output logic                  pool_enable,
  output logic [DATA_WIDTH-1:0] data_out_A_unit1,
  output logic [DATA_WIDTH-1:0] data_out_A_unit2,
  output logic [DATA_WIDTH-1:0] data_out_A_unit3,
  output logic [DATA_WIDTH-1:0] data_out_B_unit1,
  output logic [DATA_WIDTH-1:0] data_out_B_unit2,
  output logic [DATA_WIDTH-1:0] data_out_B_unit3,
  output logic                  plane_done,
  output logic                  layer_done,
  output logic                  busy
);

  localparam int LANES   = 3;
  localparam int PLANES  = IFM_DEPTH / LANES;
  localparam int COL_W   = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  // A single-plane layer still needs a 1-bit plane counter.
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(IFM_SIZE - 1);
  localparam logic [COL_W-1:0]   ROW_LAST   = COL_W'(IFM_SIZE - 2);
  localparam logic [COL_W-1:0]   ROW_STEP   = COL_W'(2);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic [COL_W-1:0]   row_reg, row_next;
  logic [PLANE_W-1:0] plane_reg, plane_next;
  // Set on the last pair of a plane; the done strobes follow one cycle later.
  logic               pend_reg, pend_next;
  logic               busy_reg, busy_next;
  logic               fifo_reg, fifo_next;
  logic               pool_reg, pool_next;
  logic               plane_done_reg, layer_done_reg;
  logic               lb_we;
  logic               plane_is_last;

  logic [LANES-1:0][DATA_WIDTH-1:0] din;
  logic [LANES-1:0][DATA_WIDTH-1:0] a_bus;
  logic [LANES-1:0][DATA_WIDTH-1:0] b_bus;

  assign din           = {data_in_unit3, data_in_unit2, data_in_unit1};
  assign plane_is_last = (plane_reg == PLANE_LAST);

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    pend_next  = 1'b0;
    fifo_next  = 1'b0;
    pool_next  = 1'b0;
    lb_we      = 1'b0;
    case (state_reg)
      IDLE: begin
        // busy is still high during the cycle between the final pair and
        // layer_done, so a start there is ignored.
        if (start && !busy_reg) begin
          state_next = EVEN;
          col_next   = '0;
          row_next   = '0;
        end
      end
      EVEN: begin
        if (in_valid) begin
          lb_we = 1'b1;
          if (col_reg == COL_LAST) begin
            col_next   = '0;
            state_next = ODD;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      ODD: begin
        if (in_valid) begin
          fifo_next = 1'b1;
          pool_next = ((int'(col_reg) % KERNAL_SIZE) == (KERNAL_SIZE - 1));
          if (col_reg == COL_LAST) begin
            col_next = '0;
            if (row_reg == ROW_LAST) begin
              row_next   = '0;
              pend_next  = 1'b1;
              state_next = plane_is_last ? IDLE : EVEN;
            end else begin
              row_next   = row_reg + ROW_STEP;
              state_next = EVEN;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    plane_next = plane_reg;
    busy_next  = busy_reg;
    if (pend_reg) begin
      plane_next = plane_is_last ? '0 : plane_reg + 1'b1;
      if (plane_is_last) begin
        busy_next = 1'b0;
      end
    end
    if (state_reg == IDLE && start && !busy_reg) begin
      busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      plane_reg      <= '0;
      pend_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      fifo_reg       <= 1'b0;
      pool_reg       <= 1'b0;
      plane_done_reg <= 1'b0;
      layer_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      plane_reg      <= plane_next;
      pend_reg       <= pend_next;
      busy_reg       <= busy_next;
      fifo_reg       <= fifo_next;
      pool_reg       <= pool_next;
      plane_done_reg <= pend_reg;
      layer_done_reg <= pend_reg && plane_is_last;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lb_mem [IFM_SIZE];
      logic [DATA_WIDTH-1:0] a_reg, b_reg;

      // Line buffer is written only in EVEN, read only in ODD, so the
      // read of a column always sees the even-row pixel.
      always_ff @(posedge clk) begin
        if (lb_we) begin
          lb_mem[col_reg] <= din[gi];
        end
      end

      // Output register doubles as the registered read of the line buffer.
      always_ff @(posedge clk) begin
        if (!reset) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (fifo_next) begin
          a_reg <= lb_mem[col_reg];
          b_reg <= din[gi];
        end
      end

      assign a_bus[gi] = a_reg;
      assign b_bus[gi] = b_reg;
    end
  endgenerate

  assign fifo_enable      = fifo_reg;
  assign pool_enable      = pool_reg;
  assign plane_done       = plane_done_reg;
  assign layer_done       = layer_done_reg;
  assign busy             = busy_reg;
  assign data_out_A_unit1 = a_bus[0];
  assign data_out_A_unit2 = a_bus[1];
  assign data_out_A_unit3 = a_bus[2];
  assign data_out_B_unit1 = b_bus[0];
  assign data_out_B_unit2 = b_bus[1];
  assign data_out_B_unit3 = b_bus[2];

endmodule

// File: tb/tb_poolb_row_pair_feeder.sv
// tb_poolb_row_pair_feeder
// Drives two feeders (IFM_SIZE=4; one plane and two planes per layer) from
// a shared pixel stream and compares every output on every cycle against a
// pixel-index model: pixel k of a plane sits at row k/N, column k%N; odd-row
// pixels pair with the stored pixel k-N.
module tb_poolb_row_pair_feeder;

  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [DW-1:0] din1, din2, din3;
  logic          start1, start2, rst1, rst2;

  logic [DW-1:0] a_o [2][3];
  logic [DW-1:0] b_o [2][3];
  logic          fe_o [2];
  logic          pe_o [2];
  logic          pd_o [2];
  logic          ld_o [2];
  logic          bz_o [2];

  poolb_row_pair_feeder #(.DATA_WIDTH(DW), .IFM_SIZE(N), .IFM_DEPTH(3), .KERNAL_SIZE(2)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .in_valid(in_valid),
    .data_in_unit1(din1), .data_in_unit2(din2), .data_in_unit3(din3),
    .fifo_enable(fe_o[0]), .pool_enable(pe_o[0]),
    .data_out_A_unit1(a_o[0][0]), .data_out_A_unit2(a_o[0][1]), .data_out_A_unit3(a_o[0][2]),
    .data_out_B_unit1(b_o[0][0]), .data_out_B_unit2(b_o[0][1]), .data_out_B_unit3(b_o[0][2]),
    .plane_done(pd_o[0]), .layer_done(ld_o[0]), .busy(bz_o[0])
  );

  poolb_row_pair_feeder #(.DATA_WIDTH(DW), .IFM_SIZE(N), .IFM_DEPTH(6), .KERNAL_SIZE(2)) dut2 (
    .clk(clk), .reset(rst2), .start(start2), .in_valid(in_valid),
    .data_in_unit1(din1), .data_in_unit2(din2), .data_in_unit3(din3),
    .fifo_enable(fe_o[1]), .pool_enable(pe_o[1]),
    .data_out_A_unit1(a_o[1][0]), .data_out_A_unit2(a_o[1][1]), .data_out_A_unit3(a_o[1][2]),
    .data_out_B_unit1(b_o[1][0]), .data_out_B_unit2(b_o[1][1]), .data_out_B_unit3(b_o[1][2]),
    .plane_done(pd_o[1]), .layer_done(ld_o[1]), .busy(bz_o[1])
  );

  // Reference model state, per DUT.
  int            planes_m [2] = '{1, 2};
  int            k_m      [2];
  int            plane_m  [2];
  bit            active_m [2];
  bit            busy_m   [2];
  bit            pend_m   [2];
  bit            pendl_m  [2];
  logic [DW-1:0] img      [2][3][N*N];
  logic [DW-1:0] exp_a    [2][3];
  logic [DW-1:0] exp_b    [2][3];
  bit            exp_fe   [2];
  bit            exp_pe   [2];
  bit            exp_pd   [2];
  bit            exp_ld   [2];

  int checks   = 0;
  int failures = 0;

  // Pair log of dut1 lane 1, plus done-pulse counters of dut2.
  logic [DW-1:0] pa_q [$];
  logic [DW-1:0] pb_q [$];
  logic [DW-1:0] pe_q [$];
  int pd2_cnt, ld2_cnt, ld2_alone;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                      input logic [DW-1:0] x3, input bit s1, input bit s2,
                      input bit r1, input bit r2);
    logic [DW-1:0] x [3];
    bit st [2];
    bit rs [2];
    bit accept;
    int r, c;
    in_valid = v; din1 = x1; din2 = x2; din3 = x3;
    start1 = s1; start2 = s2; rst1 = r1; rst2 = r2;
    x[0] = x1; x[1] = x2; x[2] = x3;
    st[0] = s1; st[1] = s2; rs[0] = r1; rs[1] = r2;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_fe[d] = 1'b0;
      exp_pe[d] = 1'b0;
      exp_pd[d] = pend_m[d];
      exp_ld[d] = pendl_m[d];
      if (!rs[d]) begin
        k_m[d] = 0; plane_m[d] = 0; active_m[d] = 0; busy_m[d] = 0;
        pend_m[d] = 0; pendl_m[d] = 0; exp_pd[d] = 0; exp_ld[d] = 0;
        for (int l = 0; l < 3; l++) begin
          exp_a[d][l] = '0;
          exp_b[d][l] = '0;
        end
      end else begin
        accept = st[d] && !active_m[d] && !busy_m[d];
        if (pend_m[d]) begin
          plane_m[d]++;
          if (pendl_m[d]) begin
            busy_m[d]  = 0;
            plane_m[d] = 0;
          end
        end
        pend_m[d]  = 0;
        pendl_m[d] = 0;
        if (accept) begin
          active_m[d] = 1;
          busy_m[d]   = 1;
          k_m[d]      = 0;
        end else if (active_m[d] && v) begin
          r = k_m[d] / N;
          c = k_m[d] % N;
          for (int l = 0; l < 3; l++) begin
            if (r % 2 == 0) begin
              img[d][l][k_m[d]] = x[l];
            end else begin
              exp_a[d][l] = img[d][l][k_m[d] - N];
              exp_b[d][l] = x[l];
            end
          end
          if (r % 2 == 1) begin
            exp_fe[d] = 1'b1;
            exp_pe[d] = (c % 2 == 1);
          end
          k_m[d]++;
          if (k_m[d] == N * N) begin
            k_m[d]  = 0;
            pend_m[d] = 1;
            if (plane_m[d] == planes_m[d] - 1) begin
              pendl_m[d]  = 1;
              active_m[d] = 0;
            end
          end
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_fifo_enable", d), {31'd0, fe_o[d]}, {31'd0, exp_fe[d]});
      chk($sformatf("d%0d_pool_enable", d), {31'd0, pe_o[d]}, {31'd0, exp_pe[d]});
      chk($sformatf("d%0d_plane_done", d), {31'd0, pd_o[d]}, {31'd0, exp_pd[d]});
      chk($sformatf("d%0d_layer_done", d), {31'd0, ld_o[d]}, {31'd0, exp_ld[d]});
      chk($sformatf("d%0d_busy", d), {31'd0, bz_o[d]}, {31'd0, busy_m[d]});
      for (int l = 0; l < 3; l++) begin
        chk($sformatf("d%0d_A_unit%0d", d, l + 1), a_o[d][l], exp_a[d][l]);
        chk($sformatf("d%0d_B_unit%0d", d, l + 1), b_o[d][l], exp_b[d][l]);
      end
      if (fe_o[d]) begin
        $display("pair dut%0d A=%0h/%0h/%0h B=%0h/%0h/%0h pool=%0b", d + 1,
                 a_o[d][0], a_o[d][1], a_o[d][2], b_o[d][0], b_o[d][1], b_o[d][2], pe_o[d]);
      end
    end
    if (fe_o[0]) begin
      pa_q.push_back(a_o[0][0]);
      pb_q.push_back(b_o[0][0]);
      pe_q.push_back({31'd0, pe_o[0]});
    end
    if (pd_o[1]) pd2_cnt++;
    if (ld_o[1]) ld2_cnt++;
    if (ld_o[1] && !pd_o[1]) ld2_alone++;
  endtask

  // Pixels first..first+count-1, lanes 2/3 offset by 0x100/0x200.
  task automatic feed(input int first, input int count, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      step(1'b1, DW'(i), DW'(i + 32'h100), DW'(i + 32'h200), 1'b0, 1'b0, 1'b1, 1'b1);
      if (gaps) step(1'b0, 32'hDEAD, 32'hBEEF, 32'hCAFE, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic clear_log();
    pa_q.delete();
    pb_q.delete();
    pe_q.delete();
  endtask

  // Required pair list for pixels 0..15: A = 0,1,2,3,8,9,10,11; B = A+4.
  task automatic check_pairs(input string tag);
    int ea;
    chk({tag, "_pair_count"}, DW'(pa_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < pa_q.size(); i++) begin
      ea = (i < 4) ? i : i + 4;
      chk($sformatf("%s_pairA%0d", tag, i), pa_q[i], DW'(ea));
      chk($sformatf("%s_pairB%0d", tag, i), pb_q[i], DW'(ea + 4));
      chk($sformatf("%s_pool%0d", tag, i), pe_q[i], DW'(i % 2));
    end
  endtask

  initial begin
    pd2_cnt = 0; ld2_cnt = 0; ld2_alone = 0;
    // Reset state.
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5, 32'h6, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Back-to-back plane, both DUTs started.
    clear_log();
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    feed(0, 16, 1'b0);
    idle(2);
    check_pairs("stream");

    // Same stream with gaps; dut2 is mid-layer so its start is ignored.
    clear_log();
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    feed(0, 16, 1'b1);
    idle(2);
    check_pairs("gapped");
    chk("d2_plane_done_count", DW'(pd2_cnt), 32'd2);
    chk("d2_layer_done_count", DW'(ld2_cnt), 32'd1);
    chk("d2_layer_done_alone", DW'(ld2_alone), 32'd0);

    // Abort after pixel 9, then valid pixels with no start, then a fresh layer.
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    feed(0, 10, 1'b0);
    step(1'b1, 32'hA, 32'h10A, 32'h20A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    feed(0, 8, 1'b0);
    clear_log();
    step(1'b1, 32'h77, 32'h88, 32'h99, 1'b1, 1'b1, 1'b1, 1'b1);
    feed(0, 16, 1'b0);
    idle(2);
    check_pairs("restart");

    // Randomized traffic, starts and rare resets; model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 149) != 0, $urandom_range(0, 149) != 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poolb_row_pair_feeder.md
Name: poolb_row_pair_feeder

Overview:
- Upstream feeder for the 3-lane pooling datapath.
- Takes the raster-order conv output stream (one pixel per lane per valid cycle).
- Buffers each even row in a per-lane line buffer. While the following odd row streams in, it presents vertically aligned row pairs (A = even-row pixel, B = odd-row pixel), plus fifo_enable/pool_enable strobes, to the pool datapath.
- Also tracks plane and layer completion.

Parameters:
- DATA_WIDTH, 32, width of each pixel word.
- IFM_SIZE, 10, rows and columns of one input plane; must be even and at least 2.
- IFM_DEPTH, 30, total channels; must be a multiple of 3 (3 lanes).
- KERNAL_SIZE, 2, pooling window; only 2 is supported.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse; begins one layer (IFM_DEPTH/3 planes per lane).
- in_valid  in  1  data_in_unit1..3 carry a valid pixel this cycle.
- data_in_unit1  in  DATA_WIDTH  lane-1 conv pixel.
- data_in_unit2  in  DATA_WIDTH  lane-2 conv pixel.
- data_in_unit3  in  DATA_WIDTH  lane-3 conv pixel.
- fifo_enable  out  1  row-pair word valid on the A/B outputs.
- pool_enable  out  1  current pair closes a 2x2 window (odd column).
- data_out_A_unit1/2/3  out  DATA_WIDTH each  even-row pixel at the current column.
- data_out_B_unit1/2/3  out  DATA_WIDTH each  odd-row pixel at the current column.
- plane_done  out  1  one-cycle pulse after the last pair of a plane.
- layer_done  out  1  one-cycle pulse after the last pair of the final plane.
- busy  out  1  high from the cycle after start until layer_done.

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs go to 0; state goes to IDLE; col, row and plane counters clear.
  - Line buffer contents are not cleared and are don't-care.
  - Reset mid-operation aborts the layer immediately; no done pulse is issued.
- States:
  - IDLE: waits for start; in_valid is ignored. start moves to EVEN and sets busy.
  - EVEN: each valid pixel is written to lb_laneN[col]; no outputs are produced. After col==IFM_SIZE-1, col wraps to 0 and the state moves to ODD.
  - ODD: each valid pixel produces a pair, registered for 1-cycle latency:
    - A = lb_laneN[col], B = data_in_unitN, fifo_enable=1.
    - pool_enable=1 only when col is odd.
    - After col==IFM_SIZE-1: row advances by 2.
    - If the plane is not finished, go to EVEN.
    - If the plane is finished, the cycle after the last pair raises plane_done and increments the plane counter.
    - If that was plane IFM_DEPTH/3-1, layer_done also pulses that cycle, busy drops and the state goes to IDLE. Otherwise go to EVEN.
- in_valid low: counters and state hold; fifo_enable and pool_enable are 0 the next cycle; A/B hold their last values.
- Output timing:
  - fifo_enable, pool_enable, plane_done and layer_done are single-cycle registered strobes.
  - A/B change only when fifo_enable is asserted.
- start while busy is ignored. start coincident with reset is ignored.
- Line buffer:
  - IFM_SIZE x DATA_WIDTH per lane.
  - In ODD, the read of lb[col] occurs before any rewrite, which is guaranteed because ODD never writes.
- Arithmetic: none. Data passes through bit-exact; ARITH_TYPE-independent.
- Counters: col is $clog2(IFM_SIZE) bits, row is $clog2(IFM_SIZE) bits, plane is $clog2(IFM_DEPTH/3) bits. All wrap to 0 exactly at their limit, never beyond.

Test Plan:
- IFM_SIZE=4, IFM_DEPTH=3:
  - Stimulus: start, then 16 back-to-back pixels 0..15 on all lanes.
  - Required: fifo_enable high for 8 cycles.
  - Required pairs (A,B): (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15).
  - Required: pool_enable only on the pairs (1,5),(3,7),(9,13),(11,15).
  - Required: plane_done and layer_done both pulse 1 cycle after (11,15).
- Same stream as above with in_valid low every other cycle: identical pair sequence, with fifo_enable gaps matching the in_valid gaps. No duplicated or lost pairs.
- Lane independence: lanes fed values +0x100 and +0x200 offsets from lane 1 -> each lane's outputs carry its own offset exactly.
- IFM_SIZE=4, IFM_DEPTH=6: two planes.
  - Required: plane_done pulses twice.
  - Required: layer_done pulses only with the second plane_done.
  - Required: busy falls on the same cycle as layer_done.
- Reset asserted after pixel 9 of plane 0:
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: a fresh start then reproduces the first scenario's result exactly.
- start pulsed mid-layer and in IDLE with in_valid=1 but no start: no effect on counters. fifo_enable stays 0 in IDLE.
